// File: rtl/mem_xfer_unit_if.sv
// Memory-side port of the transfer unit: word address, strobes, byte
// enables and data, with a single ready completion signal from memory.
interface mem_xfer_unit_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_xfer_unit.sv
// Memory transfer unit: takes one load/store request, holds it in MAR/MDR,
// runs a ready-handshaked access with lane steering, sign extension,
// misalignment rejection and a stall timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; request latched on acceptance
// ST_ACCESS | strobe asserted, waiting for mem_ready or timeout
// ST_DONE   | one-cycle done pulse, error valid; start ignored
module mem_xfer_unit #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mar,
  mem_xfer_unit_if.master   mem
);

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t      state;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [7:0]  wait_cnt;
  logic        rd_q;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  function automatic logic bad_request(input logic [1:0] sz, input logic [1:0] lo);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      2'b10:   r = (lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] r;
    case (sz)
      2'b00:   r = 4'b0001 << lo;
      2'b01:   r = lo[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Byte/half data is replicated so every lane of its size carries it;
  // byte enables pick out the one that matters.
  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Sequencer: request latch, access/timeout control and registered outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rdata     <= '0;
      mar       <= '0;
      req_write <= 1'b0;
      req_size  <= 2'b00;
      req_sign  <= 1'b0;
      wait_cnt  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mar       <= addr;
            req_write <= write;
            req_size  <= size;
            req_sign  <= sign;
            wdata_q   <= steer_wdata(size, wdata);
            wait_cnt  <= '0;
            busy      <= 1'b1;
            if (bad_request(size, addr[1:0])) begin
              state <= ST_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= ST_ACCESS;
              error <= 1'b0;
              rd_q  <= !write;
              wr_q  <= write;
              be_q  <= lane_enables(size, addr[1:0]);
            end
          end
        end
        ST_ACCESS: begin
          if (mem.mem_ready) begin
            if (!req_write) begin
              rdata <= align_load(mem.mem_rdata, req_size, mar[1:0], req_sign);
            end
            state <= ST_DONE;
            done  <= 1'b1;
            error <= 1'b0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            be_q  <= 4'b0000;
          end else if (wait_cnt == LAST_WAIT) begin
            state <= ST_DONE;
            done  <= 1'b1;
            error <= 1'b1;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            be_q  <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_addr  = {mar[ADDR_W-1:2], 2'b00};
  assign mem.mem_read  = rd_q;
  assign mem.mem_write = wr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Bench for mem_xfer_unit: directed cases from the datasheet plus random
// transfers, checked against a byte-lane arithmetic model of the unit.
module tb_mem_xfer_unit;
  localparam int ADDR_W   = 9;
  localparam int MAX_WAIT = 4;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              write = 1'b0;
  logic [1:0]        size  = 2'b00;
  logic              sign  = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [31:0]       wdata = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mar;

  mem_xfer_unit_if #(.ADDR_W(ADDR_W)) mif();

  mem_xfer_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .clear(clear), .start(start), .write(write), .size(size),
    .sign(sign), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .error(error), .rdata(rdata), .mar(mar), .mem(mif)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_error = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_bad(input logic [1:0] sz, input int a);
    if (sz == 2'b11) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input int a);
    return 4'(((1 << nbytes(sz)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit sg, input int a,
                                           input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = nbytes(sz);
    v = d >> (8 * (a % 4));
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ":busy"},  32'(busy),  32'd0);
    check({tag, ":done"},  32'(done),  32'd0);
    check({tag, ":error"}, 32'(error), 32'd0);
    check({tag, ":rdata"}, rdata,      32'd0);
    check({tag, ":mar"},   32'(mar),   32'd0);
    check({tag, ":strb"},  32'({mif.mem_read, mif.mem_write, mif.mem_be}), 32'd0);
    check({tag, ":maddr"}, 32'(mif.mem_addr), 32'd0);
  endtask

  // One request; k = wait cycles before ready (k >= MAX_WAIT means never).
  task automatic do_xfer(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                         input int a, input logic [31:0] wd, input logic [31:0] md, input int k);
    bit          bad;
    int          done_cyc;
    logic [3:0]  be;
    logic [31:0] m;
    bad = is_bad(sz, a);
    write = w; size = sz; sign = sg; addr = ADDR_W'(a); wdata = wd; start = 1'b1;
    tick();
    start = 1'b0;
    size  = 2'($urandom_range(0, 3));
    sign  = 1'($urandom_range(0, 1));
    addr  = ADDR_W'($urandom);
    wdata = $urandom;
    check({tag, ":mar"},  32'(mar),  32'(a));
    check({tag, ":busy"}, 32'(busy), 32'd1);
    if (bad) begin
      exp_error = 1'b1;
      check({tag, ":done"},  32'(done),  32'd1);
      check({tag, ":error"}, 32'(error), 32'd1);
      check({tag, ":strb"},  32'({mif.mem_read, mif.mem_write, mif.mem_be}), 32'd0);
    end else begin
      be = exp_be(sz, a);
      m  = lane_mask(be);
      done_cyc = (k < MAX_WAIT) ? 2 + k : MAX_WAIT + 1;
      for (int c = 1; c < done_cyc; c++) begin
        check({tag, ":strb"},  32'({mif.mem_read, mif.mem_write, mif.mem_be}), 32'({!w, w, be}));
        check({tag, ":maddr"}, 32'(mif.mem_addr), 32'(a & ~3));
        check({tag, ":wdata"}, mif.mem_wdata & m, exp_wdata(sz, wd) & m);
        check({tag, ":done0"}, 32'(done), 32'd0);
        mif.mem_ready = (c - 1 == k);
        mif.mem_rdata = (c - 1 == k) ? md : $urandom;
        tick();
      end
      mif.mem_ready = 1'b0;
      mif.mem_rdata = $urandom;
      if (k < MAX_WAIT) begin
        exp_error = 1'b0;
        if (!w) exp_rdata = exp_load(sz, sg, a, md);
      end else begin
        exp_error = 1'b1;
      end
      check({tag, ":done"},  32'(done),  32'd1);
      check({tag, ":error"}, 32'(error), 32'(exp_error));
      check({tag, ":strb_off"}, 32'({mif.mem_read, mif.mem_write, mif.mem_be}), 32'd0);
    end
    check({tag, ":rdata"}, rdata, exp_rdata);
    tick();
    check({tag, ":done_end"},  32'(done),  32'd0);
    check({tag, ":busy_end"},  32'(busy),  32'd0);
    check({tag, ":error_hold"}, 32'(error), 32'(exp_error));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    tick();
    tick();
    check_all_zero("reset");
    clear = 1'b1;
    tick();

    do_xfer("word_load",  1'b0, 2'b10, 1'b0, 'h010, 32'h0, 32'h80818283, 0);
    do_xfer("byte_ld_sx", 1'b0, 2'b00, 1'b1, 'h013, 32'h0, 32'h80818283, 0);
    do_xfer("byte_ld_zx", 1'b0, 2'b00, 1'b0, 'h013, 32'h0, 32'h80818283, 0);
    do_xfer("half_ld_sx", 1'b0, 2'b01, 1'b1, 'h012, 32'h0, 32'h80818283, 0);
    do_xfer("byte_store", 1'b1, 2'b00, 1'b0, 'h005, 32'h000000AB, 32'h0, 0);
    do_xfer("half_store", 1'b1, 2'b01, 1'b0, 'h006, 32'h00001234, 32'h0, 1);
    do_xfer("misalign",   1'b0, 2'b10, 1'b0, 'h006, 32'h0, 32'h0, 0);
    do_xfer("reserved",   1'b0, 2'b11, 1'b0, 'h0A4, 32'h0, 32'h0, 0);
    do_xfer("timeout",    1'b0, 2'b10, 1'b0, 'h020, 32'h0, 32'h11223344, MAX_WAIT);
    do_xfer("last_ready", 1'b0, 2'b10, 1'b0, 'h024, 32'h0, 32'hCAFEF00D, MAX_WAIT - 1);
    do_xfer("wait2_half", 1'b0, 2'b01, 1'b0, 'h0FE, 32'h0, 32'hF00D7FFF, 2);

    // Reset in the second cycle of a 3-wait load.
    write = 1'b0; size = 2'b10; sign = 1'b0; addr = ADDR_W'('h040); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    check_all_zero("mid_reset");
    check("mid_reset:wdata", mif.mem_wdata, 32'd0);
    clear = 1'b1;
    exp_rdata = '0;
    exp_error = 1'b0;
    do_xfer("after_reset", 1'b0, 2'b10, 1'b0, 'h044, 32'h0, 32'h5A5AA5A5, 0);

    // A start during DONE must not be taken.
    write = 1'b0; size = 2'b10; addr = ADDR_W'('h006); start = 1'b1;
    tick();
    check("done_start:done", 32'(done), 32'd1);
    addr = ADDR_W'('h048);
    tick();
    start = 1'b0;
    exp_error = 1'b1;
    check("done_start:busy",  32'(busy), 32'd0);
    check("done_start:read",  32'(mif.mem_read), 32'd0);
    check("done_start:mar",   32'(mar), 32'h006);
    tick();
    check("done_start:busy2", 32'(busy), 32'd0);
    check("done_start:read2", 32'(mif.mem_read), 32'd0);
    check("done_start:error", 32'(error), 32'(exp_error));

    for (int i = 0; i < 40; i++) begin
      logic [1:0] sz;
      int a;
      sz = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 511));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(nbytes(sz) - 1);
      do_xfer("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_xfer_unit.md
# mem_xfer_unit

Parametrised memory transfer unit that replaces the fixed MAR/MDR/RAM-strobe arrangement in the datapath. It accepts one load or store request from the control unit, holds it in internal MAR/MDR registers, and drives a ready-handshaked memory port. It supports byte, half-word and word transfers with lane steering and sign extension, reports misalignment, and times out on a stalled memory.

## Interface
- ADDR_W, 9, byte-address width (≥ 3).
- MAX_WAIT, 15, maximum number of cycles the memory strobe stays asserted without `mem_ready` before timeout (1..255).

Ports:
- clock  in  1  Single clock; all state changes on the rising edge.
- clear  in  1  Synchronous, active-low reset.
- start  in  1  Request strobe. Sampled only in IDLE.
- write  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign  in  1  Loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  Byte address, taken from the bus.
- wdata  in  32  Store data, right-justified.
- busy  out  1  High from the cycle after an accepted `start` through the DONE cycle.
- done  out  1  One-cycle completion pulse.
- error  out  1  Valid with `done`: misaligned access, reserved size, or timeout.
- rdata  out  32  MDR; aligned and extended load result.
- mar  out  ADDR_W  Latched request address.
- mem_addr  out  ADDR_W  Word address: `mar` with bits [1:0] forced to 0.
- mem_read  out  1  Read strobe.
- mem_write  out  1  Write strobe.
- mem_be  out  4  Byte enables; lane n = bits [8n+7:8n].
- mem_wdata  out  32  Lane-steered store data.
- mem_rdata  in  32  Read data. Valid when `mem_ready` = 1.
- mem_ready  in  1  Memory completion. Sampled only while a strobe is high.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, start = 1:
  - Latch `mar`, write, size, sign and wdata.
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] ≠ 0) or size = 11 → DONE with error = 1. No strobe is issued.
  - Otherwise → ACCESS, with the wait counter cleared.
- ACCESS:
  - `mem_read` = !write, `mem_write` = write.
  - `mem_be`: byte → one-hot at mar[1:0]; half → 0011 or 1100 selected by mar[1]; word → 1111. `mem_be` = 0000 outside ACCESS.
  - `mem_wdata`: wdata byte/half replicated across all lanes of its size; only enabled lanes are meaningful.
  - mem_ready = 1 → DONE, error = 0. For a load, `rdata` is loaded on this edge with the selected lane right-justified and extended per `sign`.
  - mem_ready = 0 → counter increments. If the counter reaches MAX_WAIT−1 with ready still low → DONE with error = 1; `rdata` is unchanged.
- DONE: done = 1 for one cycle → IDLE. `start` is ignored in DONE.
- `rdata` changes only on a successful load. Stores and errors leave it unchanged.
- `error` holds its value until the next accepted `start`.

## Timing
- Reset (clear = 0 at an edge), from any state including mid-ACCESS:
  - State → IDLE.
  - busy, done, error, mem_read, mem_write = 0; mem_be = 0000.
  - mar, rdata, counter, latched request = 0.
- Strobes and enables are registered state decodes, and drop on the same edge that leaves ACCESS.
- Zero-wait access:
  - start at edge 0 → ACCESS in cycle 1.
  - mem_ready = 1 in cycle 1 → done in cycle 2.
  - Latency is 2 cycles; `rdata` is valid in the done cycle.
- k wait cycles → done at cycle 2+k.
- Misaligned or reserved request → done + error in cycle 1; no strobe.
- Timeout → strobe high for exactly MAX_WAIT cycles; done + error in cycle MAX_WAIT+1.
- `mem_ready` high in the last permitted cycle counts as success, not timeout.
- Back-to-back requests: the earliest next `start` is accepted in the cycle after done (IDLE).

## Test plan
- Word load, addr 0x010, mem_rdata 0x80818283, ready immediate → mem_addr 0x010, done at cycle 2, rdata 0x80818283, error 0.
- Byte load, addr 0x013, same data:
  - sign = 1 → rdata 0xFFFFFF80.
  - sign = 0 → 0x00000080.
- Half load, addr 0x012, sign = 1 → 0xFFFF8081.
- Byte store, addr 0x005, wdata 0x000000AB → mem_addr 0x004, mem_be 0010, mem_wdata[15:8] 0xAB; rdata unchanged.
- Half store, addr 0x006, wdata 0x1234 → mem_be 1100, mem_wdata[31:16] 0x1234.
- Misaligned and reserved requests: word load at addr 0x006, and size = 11 at any address → done + error in cycle 1, mem_read never asserted.
- MAX_WAIT = 4, ready held low:
  - mem_read high for cycles 1–4; done + error in cycle 5; rdata unchanged.
  - Repeat with ready high in cycle 4 → success, done in cycle 5.
- clear = 0 during cycle 2 of a 3-wait load:
  - All outputs are zero at the next edge.
  - A start issued afterwards completes normally.
  - A start pulsed during DONE is ignored.
